// File: rtl/axi_stream_dw_upsizer.sv
// AXI-Stream width upsizer: packs Ratio narrow beats into one wide beat, lane 0 first.
// Packets closed early by tlast or a tid/tdest/tuser change have their unfilled lanes nulled.
module axi_stream_dw_upsizer #(
  parameter int DataWidthIn  = 8,
  parameter int DataWidthOut = 32,
  parameter int IdWidth      = 0,
  parameter int DestWidth    = 0,
  parameter int UserWidth    = 0,
  localparam int KeepIn      = DataWidthIn / 8,
  localparam int KeepOut     = DataWidthOut / 8,
  localparam int IdW         = (IdWidth > 0) ? IdWidth : 1,
  localparam int DestW       = (DestWidth > 0) ? DestWidth : 1,
  localparam int UserW       = (UserWidth > 0) ? UserWidth : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DataWidthIn-1:0]  i_in_tdata,
  input  logic [KeepIn-1:0]       i_in_tstrb,
  input  logic [KeepIn-1:0]       i_in_tkeep,
  input  logic                    i_in_tlast,
  input  logic [IdW-1:0]          i_in_tid,
  input  logic [DestW-1:0]        i_in_tdest,
  input  logic [UserW-1:0]        i_in_tuser,
  input  logic                    i_in_tvalid,
  output logic                    o_in_tready,
  output logic [DataWidthOut-1:0] o_out_tdata,
  output logic [KeepOut-1:0]      o_out_tstrb,
  output logic [KeepOut-1:0]      o_out_tkeep,
  output logic                    o_out_tlast,
  output logic [IdW-1:0]          o_out_tid,
  output logic [DestW-1:0]        o_out_tdest,
  output logic [UserW-1:0]        o_out_tuser,
  output logic                    o_out_tvalid,
  input  logic                    i_out_tready
);

  localparam int Ratio = DataWidthOut / DataWidthIn;
  localparam int IdxW  = (Ratio > 2) ? $clog2(Ratio) : 1;

  if ((DataWidthIn % 8) != 0 || Ratio < 2 || Ratio * DataWidthIn != DataWidthOut) begin : g_bad_params
    $error("axi_stream_dw_upsizer: DataWidthOut must be Ratio*DataWidthIn with Ratio >= 2, DataWidthIn a multiple of 8");
  end

  logic [IdxW-1:0]         r_idx;
  logic                    r_pend;
  logic [DataWidthOut-1:0] r_acc_data;
  logic [KeepOut-1:0]      r_acc_keep;
  logic [KeepOut-1:0]      r_acc_strb;
  logic [IdW-1:0]          r_sb_id;
  logic [DestW-1:0]        r_sb_dest;
  logic [UserW-1:0]        r_sb_user;

  logic [DataWidthOut-1:0] r_out_data;
  logic [KeepOut-1:0]      r_out_keep;
  logic [KeepOut-1:0]      r_out_strb;
  logic                    r_out_last;
  logic [IdW-1:0]          r_out_id;
  logic [DestW-1:0]        r_out_dest;
  logic [UserW-1:0]        r_out_user;
  logic                    r_out_valid;

  logic w_out_free;
  logic w_in_ready;
  logic w_accept;
  logic w_sb_diff;
  logic w_break;
  logic w_complete;

  // Per-lane views: merged (accumulator + incoming beat) and three masked variants.
  logic [DataWidthOut-1:0] w_merge_data, w_cmp_data, w_brk_data, w_pnd_data;
  logic [KeepOut-1:0]      w_merge_keep, w_cmp_keep, w_brk_keep, w_pnd_keep;
  logic [KeepOut-1:0]      w_merge_strb, w_cmp_strb, w_brk_strb, w_pnd_strb;

  assign w_out_free = !r_out_valid || i_out_tready;
  assign w_in_ready = !rst_i && w_out_free && !r_pend;
  assign w_accept   = i_in_tvalid && w_in_ready;

  assign w_sb_diff = ((IdWidth > 0)   && (i_in_tid   != r_sb_id))   ||
                     ((DestWidth > 0) && (i_in_tdest != r_sb_dest)) ||
                     ((UserWidth > 0) && (i_in_tuser != r_sb_user));
  assign w_break    = w_accept && (r_idx != '0) && w_sb_diff;
  assign w_complete = w_accept && !w_break &&
                      ((r_idx == IdxW'(Ratio - 1)) || i_in_tlast);

  for (genvar gi = 0; gi < Ratio; gi++) begin : g_lane
    logic w_sel;
    logic w_le;
    logic w_lt;
    assign w_sel = (r_idx == IdxW'(gi));
    assign w_le  = (IdxW'(gi) <= r_idx);
    assign w_lt  = (IdxW'(gi) <  r_idx);

    assign w_merge_data[gi*DataWidthIn +: DataWidthIn] =
      w_sel ? i_in_tdata : r_acc_data[gi*DataWidthIn +: DataWidthIn];
    assign w_merge_keep[gi*KeepIn +: KeepIn] =
      w_sel ? i_in_tkeep : r_acc_keep[gi*KeepIn +: KeepIn];
    assign w_merge_strb[gi*KeepIn +: KeepIn] =
      w_sel ? i_in_tstrb : r_acc_strb[gi*KeepIn +: KeepIn];

    assign w_cmp_data[gi*DataWidthIn +: DataWidthIn] =
      w_le ? w_merge_data[gi*DataWidthIn +: DataWidthIn] : '0;
    assign w_cmp_keep[gi*KeepIn +: KeepIn] = w_le ? w_merge_keep[gi*KeepIn +: KeepIn] : '0;
    assign w_cmp_strb[gi*KeepIn +: KeepIn] = w_le ? w_merge_strb[gi*KeepIn +: KeepIn] : '0;

    assign w_brk_data[gi*DataWidthIn +: DataWidthIn] =
      w_lt ? r_acc_data[gi*DataWidthIn +: DataWidthIn] : '0;
    assign w_brk_keep[gi*KeepIn +: KeepIn] = w_lt ? r_acc_keep[gi*KeepIn +: KeepIn] : '0;
    assign w_brk_strb[gi*KeepIn +: KeepIn] = w_lt ? r_acc_strb[gi*KeepIn +: KeepIn] : '0;

    assign w_pnd_data[gi*DataWidthIn +: DataWidthIn] =
      (gi == 0) ? r_acc_data[gi*DataWidthIn +: DataWidthIn] : '0;
    assign w_pnd_keep[gi*KeepIn +: KeepIn] = (gi == 0) ? r_acc_keep[gi*KeepIn +: KeepIn] : '0;
    assign w_pnd_strb[gi*KeepIn +: KeepIn] = (gi == 0) ? r_acc_strb[gi*KeepIn +: KeepIn] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idx       <= '0;
      r_pend      <= 1'b0;
      r_acc_data  <= '0;
      r_acc_keep  <= '0;
      r_acc_strb  <= '0;
      r_sb_id     <= '0;
      r_sb_dest   <= '0;
      r_sb_user   <= '0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_strb  <= '0;
      r_out_last  <= 1'b0;
      r_out_id    <= '0;
      r_out_dest  <= '0;
      r_out_user  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && i_out_tready) begin
        r_out_valid <= 1'b0;
      end
      if (r_pend && w_out_free) begin
        // Single-lane word left behind by a breaking beat that also carried tlast.
        r_out_valid <= 1'b1;
        r_out_data  <= w_pnd_data;
        r_out_keep  <= w_pnd_keep;
        r_out_strb  <= w_pnd_strb;
        r_out_last  <= 1'b1;
        r_out_id    <= r_sb_id;
        r_out_dest  <= r_sb_dest;
        r_out_user  <= r_sb_user;
        r_pend      <= 1'b0;
      end else if (w_break) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_brk_data;
        r_out_keep  <= w_brk_keep;
        r_out_strb  <= w_brk_strb;
        r_out_last  <= 1'b0;
        r_out_id    <= r_sb_id;
        r_out_dest  <= r_sb_dest;
        r_out_user  <= r_sb_user;
        r_sb_id     <= i_in_tid;
        r_sb_dest   <= i_in_tdest;
        r_sb_user   <= i_in_tuser;
        r_acc_data[DataWidthIn-1:0] <= i_in_tdata;
        r_acc_keep[KeepIn-1:0]      <= i_in_tkeep;
        r_acc_strb[KeepIn-1:0]      <= i_in_tstrb;
        r_idx       <= i_in_tlast ? '0 : IdxW'(1);
        r_pend      <= i_in_tlast;
      end else if (w_complete) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_cmp_data;
        r_out_keep  <= w_cmp_keep;
        r_out_strb  <= w_cmp_strb;
        r_out_last  <= i_in_tlast;
        r_out_id    <= (r_idx == '0) ? i_in_tid   : r_sb_id;
        r_out_dest  <= (r_idx == '0) ? i_in_tdest : r_sb_dest;
        r_out_user  <= (r_idx == '0) ? i_in_tuser : r_sb_user;
        r_idx       <= '0;
      end else if (w_accept) begin
        r_acc_data <= w_merge_data;
        r_acc_keep <= w_merge_keep;
        r_acc_strb <= w_merge_strb;
        r_idx      <= r_idx + IdxW'(1);
        if (r_idx == '0) begin
          r_sb_id   <= i_in_tid;
          r_sb_dest <= i_in_tdest;
          r_sb_user <= i_in_tuser;
        end
      end
    end
  end

  assign o_in_tready  = w_in_ready;
  assign o_out_tdata  = r_out_data;
  assign o_out_tkeep  = r_out_keep;
  assign o_out_tstrb  = r_out_strb;
  assign o_out_tlast  = r_out_last;
  assign o_out_tid    = r_out_id;
  assign o_out_tdest  = r_out_dest;
  assign o_out_tuser  = r_out_user;
  assign o_out_tvalid = r_out_valid;

endmodule
